// File: rtl/cu_mmio_return_responder_pkg.sv
// Shared types, register map and helpers for the CU-Control MMIO responder.
// Register word addresses are the historical byte offsets shifted down by two.
package cu_mmio_return_responder_pkg;

  typedef logic [0:63] mmio_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RESP
  } state_t;

  localparam int NUM_MB  = 3;
  localparam int MB_RET  = 0;
  localparam int MB_DONE = 1;
  localparam int MB_ERR  = 2;

  function automatic logic [0:23] word_addr(input logic [25:0] byte_off);
    return byte_off[25:2];
  endfunction

  localparam logic [0:23] CU_CONFIGURE_ADDR       = word_addr(26'h3FFFFE8);
  localparam logic [0:23] CU_CONFIGURE_2_ADDR     = word_addr(26'h3FFFF28);
  localparam logic [0:23] CU_STATUS_ADDR          = word_addr(26'h3FFFFE0);
  localparam logic [0:23] CU_RETURN_ADDR          = word_addr(26'h3FFFFD8);
  localparam logic [0:23] CU_RETURN_ACK_ADDR      = word_addr(26'h3FFFFD0);
  localparam logic [0:23] CU_RETURN_DONE_ADDR     = word_addr(26'h3FFFFC8);
  localparam logic [0:23] CU_RETURN_DONE_ACK_ADDR = word_addr(26'h3FFFFC0);
  localparam logic [0:23] ERROR_REG_ADDR          = word_addr(26'h3FFFFB8);
  localparam logic [0:23] ERROR_REG_ACK_ADDR      = word_addr(26'h3FFFFB0);

  // Indexed by MB_RET / MB_DONE / MB_ERR
  localparam logic [0:23] MB_DATA_ADDR [NUM_MB] =
    '{CU_RETURN_ADDR, CU_RETURN_DONE_ADDR, ERROR_REG_ADDR};
  localparam logic [0:23] MB_ACK_ADDR [NUM_MB] =
    '{CU_RETURN_ACK_ADDR, CU_RETURN_DONE_ACK_ADDR, ERROR_REG_ACK_ADDR};

  // The low address bit only picks a 32-bit half, so it is excluded from decode.
  function automatic logic addr_hit(input logic [0:23] addr, input logic [0:23] reg_addr);
    return addr[0:22] == reg_addr[0:22];
  endfunction

  function automatic mmio_word_t merge_write(input mmio_word_t old_word, input mmio_word_t wr_data,
                                             input logic dw, input logic low_half);
    mmio_word_t result;
    result = old_word;
    if (dw)
      result = wr_data;
    else if (low_half)
      result[32:63] = wr_data[32:63];
    else
      result[0:31] = wr_data[0:31];
    return result;
  endfunction

endpackage

// File: rtl/cu_mmio_mailbox.sv
// Single-entry mailbox: captures one pushed word, holds it for host reads,
// and empties when the host acknowledges it.
module cu_mmio_mailbox
  import cu_mmio_return_responder_pkg::*;
(
  input  logic       clock,
  input  logic       rstn,
  input  logic       push_valid,
  output logic       push_ready,
  input  mmio_word_t push_data,
  input  logic       clear,
  output mmio_word_t rd_data
);

  logic       full_reg;
  logic       live_reg;
  mmio_word_t data_reg;

  // live_reg keeps ready low throughout reset and for the edge that ends it
  assign push_ready = live_reg & ~full_reg;
  assign rd_data    = data_reg;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      live_reg <= 1'b0;
      full_reg <= 1'b0;
      data_reg <= '0;
    end else begin
      live_reg <= 1'b1;
      if (push_valid && push_ready) begin
        full_reg <= 1'b1;
        data_reg <= push_data;
      end else if (clear) begin
        full_reg <= 1'b0;
        data_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/cu_mmio_return_responder.sv
// Host-facing MMIO responder for the CU-Control window: config registers,
// live status and three acknowledge-cleared return mailboxes.
module cu_mmio_return_responder
  import cu_mmio_return_responder_pkg::*;
#(
  parameter int ADDR_BITS  = 24,
  parameter int DATA_BITS  = 64,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 mmio_req_valid,
  input  logic                 mmio_req_rnw,
  input  logic                 mmio_req_dw,
  input  logic [0:ADDR_BITS-1] mmio_req_addr,
  input  logic [0:DATA_BITS-1] mmio_req_data,
  output logic                 mmio_ack,
  output logic [0:DATA_BITS-1] mmio_rsp_data,
  output logic                 mmio_rsp_parity,
  output logic [0:DATA_BITS-1] cu_configure,
  output logic [0:DATA_BITS-1] cu_configure_2,
  input  logic [0:DATA_BITS-1] cu_status_in,
  input  logic                 ret_valid,
  output logic                 ret_ready,
  input  logic [0:DATA_BITS-1] ret_data,
  input  logic                 done_valid,
  output logic                 done_ready,
  input  logic [0:DATA_BITS-1] done_data,
  input  logic                 err_valid,
  output logic                 err_ready,
  input  logic [0:DATA_BITS-1] err_data
);

  state_t               state_reg, state_next;
  logic                 req_rnw_reg, req_dw_reg;
  logic [0:ADDR_BITS-1] req_addr_reg;
  mmio_word_t           req_data_reg;
  mmio_word_t           cfg_reg, cfg_next, cfg2_reg, cfg2_next;
  mmio_word_t           rsp_data_reg, rsp_data_next;
  logic                 parity_reg, parity_next;
  mmio_word_t           rd_word;
  logic [0:31]          rd_half;

  logic [NUM_MB-1:0]    mb_valid, mb_ready, mb_clear, mb_rd_hit;
  mmio_word_t           mb_push_data [NUM_MB];
  mmio_word_t           mb_rd_data   [NUM_MB];

  assign mb_valid             = {err_valid, done_valid, ret_valid};
  assign mb_push_data[MB_RET]  = ret_data;
  assign mb_push_data[MB_DONE] = done_data;
  assign mb_push_data[MB_ERR]  = err_data;
  assign ret_ready            = mb_ready[MB_RET];
  assign done_ready           = mb_ready[MB_DONE];
  assign err_ready            = mb_ready[MB_ERR];

  generate
    for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_mailbox
      assign mb_rd_hit[gi] = addr_hit(req_addr_reg, MB_DATA_ADDR[gi]);
      assign mb_clear[gi]  = (state_reg == ST_DECODE) && !req_rnw_reg &&
                             addr_hit(req_addr_reg, MB_ACK_ADDR[gi]);

      cu_mmio_mailbox u_mailbox (
        .clock      (clock),
        .rstn       (rstn),
        .push_valid (mb_valid[gi]),
        .push_ready (mb_ready[gi]),
        .push_data  (mb_push_data[gi]),
        .clear      (mb_clear[gi]),
        .rd_data    (mb_rd_data[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    if (addr_hit(req_addr_reg, CU_CONFIGURE_ADDR))
      rd_word = cfg_reg;
    else if (addr_hit(req_addr_reg, CU_CONFIGURE_2_ADDR))
      rd_word = cfg2_reg;
    else if (addr_hit(req_addr_reg, CU_STATUS_ADDR))
      rd_word = cu_status_in;
    for (int i = 0; i < NUM_MB; i++)
      if (mb_rd_hit[i])
        rd_word = mb_rd_data[i];
    rd_half = req_addr_reg[ADDR_BITS-1] ? rd_word[32:63] : rd_word[0:31];
  end

  always_comb begin
    state_next    = state_reg;
    cfg_next      = cfg_reg;
    cfg2_next     = cfg2_reg;
    rsp_data_next = rsp_data_reg;
    parity_next   = parity_reg;
    case (state_reg)
      ST_IDLE:
        if (mmio_req_valid)
          state_next = ST_DECODE;
      ST_DECODE: begin
        state_next = ST_RESP;
        if (req_rnw_reg) begin
          rsp_data_next = req_dw_reg ? rd_word : {rd_half, rd_half};
          parity_next   = PARITY_ODD ? ~^rsp_data_next : ^rsp_data_next;
        end else if (addr_hit(req_addr_reg, CU_CONFIGURE_ADDR)) begin
          cfg_next = merge_write(cfg_reg, req_data_reg, req_dw_reg, req_addr_reg[ADDR_BITS-1]);
        end else if (addr_hit(req_addr_reg, CU_CONFIGURE_2_ADDR)) begin
          cfg2_next = merge_write(cfg2_reg, req_data_reg, req_dw_reg, req_addr_reg[ADDR_BITS-1]);
        end
      end
      ST_RESP:
        state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      req_rnw_reg  <= 1'b0;
      req_dw_reg   <= 1'b0;
      req_addr_reg <= '0;
      req_data_reg <= '0;
      cfg_reg      <= '0;
      cfg2_reg     <= '0;
      rsp_data_reg <= '0;
      parity_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cfg_reg      <= cfg_next;
      cfg2_reg     <= cfg2_next;
      rsp_data_reg <= rsp_data_next;
      parity_reg   <= parity_next;
      // Requests arriving outside IDLE are dropped, so only latch here
      if (state_reg == ST_IDLE && mmio_req_valid) begin
        req_rnw_reg  <= mmio_req_rnw;
        req_dw_reg   <= mmio_req_dw;
        req_addr_reg <= mmio_req_addr;
        req_data_reg <= mmio_req_data;
      end
    end
  end

  assign mmio_ack        = (state_reg == ST_RESP);
  assign mmio_rsp_data   = rsp_data_reg;
  assign mmio_rsp_parity = parity_reg;
  assign cu_configure    = cfg_reg;
  assign cu_configure_2  = cfg2_reg;

endmodule

// File: tb/tb_cu_mmio_return_responder.sv
// Randomised bench for cu_mmio_return_responder against a register-map level model.
module tb_cu_mmio_return_responder;

  localparam logic [23:0] A_CFG      = 24'hFFFFFA;
  localparam logic [23:0] A_CFG2     = 24'hFFFFCA;
  localparam logic [23:0] A_STATUS   = 24'hFFFFF8;
  localparam logic [23:0] A_RET      = 24'hFFFFF6;
  localparam logic [23:0] A_RET_ACK  = 24'hFFFFF4;
  localparam logic [23:0] A_DONE     = 24'hFFFFF2;
  localparam logic [23:0] A_DONE_ACK = 24'hFFFFF0;
  localparam logic [23:0] A_ERR      = 24'hFFFFEE;
  localparam logic [23:0] A_ERR_ACK  = 24'hFFFFEC;
  localparam logic [23:0] A_UNMAPPED = 24'h000010;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rstn;
  logic        req_valid, req_rnw, req_dw;
  logic [23:0] req_addr;
  logic [63:0] req_data;
  logic        mmio_ack, mmio_rsp_parity;
  logic [63:0] mmio_rsp_data, cu_configure, cu_configure_2, cu_status_in;
  logic        ret_valid, ret_ready, done_valid, done_ready, err_valid, err_ready;
  logic [63:0] ret_data, done_data, err_data;

  cu_mmio_return_responder dut (
    .clock(clock), .rstn(rstn),
    .mmio_req_valid(req_valid), .mmio_req_rnw(req_rnw), .mmio_req_dw(req_dw),
    .mmio_req_addr(req_addr), .mmio_req_data(req_data),
    .mmio_ack(mmio_ack), .mmio_rsp_data(mmio_rsp_data), .mmio_rsp_parity(mmio_rsp_parity),
    .cu_configure(cu_configure), .cu_configure_2(cu_configure_2), .cu_status_in(cu_status_in),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_data(ret_data),
    .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
    .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: register contents and mailbox occupancy (0=ret, 1=done, 2=err)
  logic [63:0] m_cfg, m_cfg2;
  bit          m_full [3];
  logic [63:0] m_data [3];

  task automatic model_reset();
    m_cfg  = '0;
    m_cfg2 = '0;
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
    end
  endtask

  function automatic logic [63:0] model_read(input bit dw, input logic [23:0] a);
    logic [63:0] w;
    logic [31:0] h;
    case (a & 24'hFFFFFE)
      A_CFG:    w = m_cfg;
      A_CFG2:   w = m_cfg2;
      A_STATUS: w = cu_status_in;
      A_RET:    w = m_full[0] ? m_data[0] : 64'd0;
      A_DONE:   w = m_full[1] ? m_data[1] : 64'd0;
      A_ERR:    w = m_full[2] ? m_data[2] : 64'd0;
      default:  w = 64'd0;
    endcase
    if (dw) return w;
    h = (a % 2 == 1) ? w[31:0] : w[63:32];
    return {h, h};
  endfunction

  function automatic logic [63:0] merged(input logic [63:0] old, input logic [63:0] d,
                                         input bit dw, input logic [23:0] a);
    if (dw) return d;
    if (a % 2 == 1) return {old[63:32], d[31:0]};
    return {d[63:32], old[31:0]};
  endfunction

  task automatic model_write(input bit dw, input logic [23:0] a, input logic [63:0] d);
    case (a & 24'hFFFFFE)
      A_CFG:      m_cfg  = merged(m_cfg, d, dw, a);
      A_CFG2:     m_cfg2 = merged(m_cfg2, d, dw, a);
      A_RET_ACK:  begin m_full[0] = 1'b0; m_data[0] = '0; end
      A_DONE_ACK: begin m_full[1] = 1'b0; m_data[1] = '0; end
      A_ERR_ACK:  begin m_full[2] = 1'b0; m_data[2] = '0; end
      default: ;
    endcase
  endtask

  // One MMIO transaction; acks = ack seen at {T+1, T+2, T+3}, rdy = {err,done,ret} at T+2
  task automatic mmio(input bit rnw, input bit dw, input logic [23:0] a, input logic [63:0] d,
                      output logic [2:0] acks, output logic [63:0] rd, output logic par,
                      output logic [2:0] rdy);
    @(negedge clock);
    req_valid = 1'b1; req_rnw = rnw; req_dw = dw; req_addr = a; req_data = d;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    acks[2] = mmio_ack;
    @(posedge clock); @(negedge clock);
    acks[1] = mmio_ack;
    rd  = mmio_rsp_data;
    par = mmio_rsp_parity;
    rdy = {err_ready, done_ready, ret_ready};
    @(posedge clock); @(negedge clock);
    acks[0] = mmio_ack;
    if (!rnw) model_write(dw, a, d);
    $display("xact %s dw=%0d addr=%06h wdata=%016h rdata=%016h acks=%03b",
             rnw ? "RD" : "WR", dw, a, d, rd, acks);
  endtask

  task automatic push_mb(input int i, input logic [63:0] d, output logic rdy);
    @(negedge clock);
    case (i)
      0: begin ret_valid  = 1'b1; ret_data  = d; rdy = ret_ready;  end
      1: begin done_valid = 1'b1; done_data = d; rdy = done_ready; end
      default: begin err_valid = 1'b1; err_data = d; rdy = err_ready; end
    endcase
    @(posedge clock); @(negedge clock);
    ret_valid = 1'b0; done_valid = 1'b0; err_valid = 1'b0;
    if (!m_full[i]) begin
      m_full[i] = 1'b1;
      m_data[i] = d;
    end
    $display("push mb%0d data=%016h ready=%0d", i, d, rdy);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({mmio_ack, ret_ready, done_ready, err_ready} !== 4'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %04b expected 0000",
                         {mmio_ack, ret_ready, done_ready, err_ready});
    end
    n_checks++;
    if ({cu_configure, cu_configure_2, mmio_rsp_data} !== '0) begin
      n_fail++; $display("FAIL reset_regs: cfg=%h cfg2=%h rsp=%h expected 0",
                         cu_configure, cu_configure_2, mmio_rsp_data);
    end
    rstn = 1'b1;
    model_reset();
    @(posedge clock); @(negedge clock);
    n_checks++;
    if ({ret_ready, done_ready, err_ready, mmio_ack} !== 4'b1110) begin
      n_fail++; $display("FAIL ready_after_reset: got %04b expected 1110",
                         {ret_ready, done_ready, err_ready, mmio_ack});
    end
  endtask

  task automatic test_config();
    logic [2:0] acks, rdy; logic [63:0] rd; logic par;
    mmio(1'b0, 1'b1, A_CFG, 64'h0123456789ABCDEF, acks, rd, par, rdy);
    n_checks++;
    if (acks !== 3'b010) begin
      n_fail++; $display("FAIL cfg_write_ack: got %03b expected 010", acks);
    end
    n_checks++;
    if (cu_configure !== 64'h0123456789ABCDEF) begin
      n_fail++; $display("FAIL cfg_write: got %h expected 0123456789abcdef", cu_configure);
    end
    mmio(1'b1, 1'b1, A_CFG, 64'd0, acks, rd, par, rdy);
    n_checks++;
    if (acks !== 3'b010 || rd !== 64'h0123456789ABCDEF || par !== ~^rd) begin
      n_fail++; $display("FAIL cfg_readback: acks=%03b data=%h par=%b expected 010 0123456789abcdef %b",
                         acks, rd, par, ~^(64'h0123456789ABCDEF));
    end
    // 32-bit half writes to CONFIGURE_2
    for (int k = 0; k < 4; k++) begin
      logic [31:0] v;
      logic [23:0] a;
      v = $urandom;
      a = A_CFG2 | 24'(k % 2);
      mmio(1'b0, 1'b0, a, {v, v}, acks, rd, par, rdy);
      n_checks++;
      if (cu_configure_2 !== m_cfg2) begin
        n_fail++; $display("FAIL cfg2_half_write: got %h expected %h", cu_configure_2, m_cfg2);
      end
    end
  endtask

  task automatic test_mailbox();
    logic [2:0] acks, rdy; logic [63:0] rd; logic par; logic pr;
    push_mb(0, 64'h00000000DEAD0001, pr);
    n_checks++;
    if (pr !== 1'b1 || ret_ready !== 1'b0) begin
      n_fail++; $display("FAIL ret_push: ready_before=%b ready_after=%b expected 1 0", pr, ret_ready);
    end
    for (int k = 0; k < 2; k++) begin
      mmio(1'b1, 1'b1, A_RET, 64'd0, acks, rd, par, rdy);
      n_checks++;
      if (rd !== 64'h00000000DEAD0001 || par !== ~^rd) begin
        n_fail++; $display("FAIL ret_read%0d: got %h par=%b expected 00000000dead0001", k, rd, par);
      end
    end
    mmio(1'b0, 1'b1, A_RET_ACK, 64'h5A5A, acks, rd, par, rdy);
    n_checks++;
    if (acks !== 3'b010 || ret_ready !== 1'b1) begin
      n_fail++; $display("FAIL ret_ack: acks=%03b ready=%b expected 010 1", acks, ret_ready);
    end
    mmio(1'b1, 1'b1, A_RET, 64'd0, acks, rd, par, rdy);
    n_checks++;
    if (rd !== 64'd0) begin
      n_fail++; $display("FAIL ret_read_empty: got %h expected 0", rd);
    end
    mmio(1'b0, 1'b1, A_DONE_ACK, 64'd1, acks, rd, par, rdy);
    n_checks++;
    if (acks !== 3'b010 || done_ready !== 1'b1) begin
      n_fail++; $display("FAIL ack_while_empty: acks=%03b ready=%b expected 010 1", acks, done_ready);
    end
  endtask

  task automatic test_ack_with_push();
    logic [2:0] acks, rdy; logic [63:0] rd, old_e, new_e; logic par; logic pr;
    old_e = {$urandom, $urandom};
    new_e = {$urandom, $urandom};
    push_mb(2, old_e, pr);
    @(negedge clock);
    err_valid = 1'b1; err_data = new_e;
    mmio(1'b0, 1'b1, A_ERR_ACK, 64'd0, acks, rd, par, rdy);
    n_checks++;
    if (rdy[2] !== 1'b1 || err_ready !== 1'b0) begin
      n_fail++; $display("FAIL err_ack_push: ready_at_ack=%b ready_after=%b expected 1 0", rdy[2], err_ready);
    end
    err_valid = 1'b0;
    m_full[2] = 1'b1;
    m_data[2] = new_e;
    mmio(1'b1, 1'b1, A_ERR, 64'd0, acks, rd, par, rdy);
    n_checks++;
    if (rd !== new_e) begin
      n_fail++; $display("FAIL err_new_capture: got %h expected %h (old %h)", rd, new_e, old_e);
    end
  endtask

  task automatic test_status32();
    logic [2:0] acks, rdy; logic [63:0] rd; logic par;
    cu_status_in = 64'h11112222_33334444;
    mmio(1'b1, 1'b0, A_STATUS, 64'd0, acks, rd, par, rdy);
    n_checks++;
    if (rd !== 64'h11112222_11112222 || par !== ~^rd) begin
      n_fail++; $display("FAIL status_lo_half: got %h par=%b expected 1111222211112222", rd, par);
    end
    mmio(1'b1, 1'b0, A_STATUS | 24'd1, 64'd0, acks, rd, par, rdy);
    n_checks++;
    if (rd !== 64'h33334444_33334444 || par !== ~^rd) begin
      n_fail++; $display("FAIL status_hi_half: got %h par=%b expected 3333444433334444", rd, par);
    end
  endtask

  task automatic test_unmapped();
    logic [2:0] acks, rdy; logic [63:0] rd, exp_cfg; logic par;
    mmio(1'b1, 1'b1, A_UNMAPPED, 64'd0, acks, rd, par, rdy);
    n_checks++;
    if (acks !== 3'b010 || rd !== 64'd0) begin
      n_fail++; $display("FAIL unmapped_read: acks=%03b data=%h expected 010 0", acks, rd);
    end
    exp_cfg = m_cfg;
    mmio(1'b0, 1'b1, A_STATUS, 64'hFFFF_FFFF_FFFF_FFFF, acks, rd, par, rdy);
    mmio(1'b0, 1'b1, A_UNMAPPED, 64'hFFFF_FFFF_FFFF_FFFF, acks, rd, par, rdy);
    n_checks++;
    if (acks !== 3'b010 || cu_configure !== exp_cfg || cu_configure_2 !== m_cfg2) begin
      n_fail++; $display("FAIL ro_write_ignored: acks=%03b cfg=%h cfg2=%h expected 010 %h %h",
                         acks, cu_configure, cu_configure_2, exp_cfg, m_cfg2);
    end
  endtask

  task automatic test_drop();
    logic [2:0] acks;
    @(negedge clock);
    req_valid = 1'b1; req_rnw = 1'b1; req_dw = 1'b1; req_addr = A_CFG; req_data = '0;
    @(posedge clock); @(negedge clock);
    req_rnw = 1'b0; req_data = ~m_cfg;
    acks[2] = mmio_ack;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    acks[1] = mmio_ack;
    n_checks++;
    if (mmio_rsp_data !== m_cfg) begin
      n_fail++; $display("FAIL drop_read_data: got %h expected %h", mmio_rsp_data, m_cfg);
    end
    @(posedge clock); @(negedge clock);
    acks[0] = mmio_ack;
    @(posedge clock); @(negedge clock);
    n_checks++;
    if ({acks, mmio_ack} !== 4'b0100 || cu_configure !== m_cfg) begin
      n_fail++; $display("FAIL drop_second_req: acks=%04b cfg=%h expected 0100 %h",
                         {acks, mmio_ack}, cu_configure, m_cfg);
    end
  endtask

  task automatic test_reset_mid();
    int ack_seen;
    ack_seen = 0;
    @(negedge clock);
    req_valid = 1'b1; req_rnw = 1'b0; req_dw = 1'b1; req_addr = A_CFG; req_data = 64'hCAFE;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); @(negedge clock);
      if (mmio_ack === 1'b1) ack_seen++;
    end
    rstn = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); @(negedge clock);
      if (mmio_ack === 1'b1) ack_seen++;
    end
    n_checks++;
    if (ack_seen != 0 || cu_configure !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid_xact: acks_seen=%0d cfg=%h expected 0 0", ack_seen, cu_configure);
    end
  endtask

  task automatic test_random();
    logic [23:0] addrs [10];
    logic [2:0] acks, rdy; logic [63:0] rd, exp; logic par; logic pr;
    bit rnw, dw;
    logic [23:0] a;
    addrs = '{A_CFG, A_CFG2, A_STATUS, A_RET, A_RET_ACK, A_DONE, A_DONE_ACK, A_ERR, A_ERR_ACK, A_UNMAPPED};
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bit was_full;
          was_full = m_full[i];
          push_mb(i, {$urandom, $urandom}, pr);
          n_checks++;
          if (pr !== !was_full) begin
            n_fail++; $display("FAIL rnd_ready mb%0d: got %b expected %b", i, pr, !was_full);
          end
        end
      end
      cu_status_in = {$urandom, $urandom};
      rnw = $urandom_range(0, 1);
      dw  = $urandom_range(0, 1);
      a   = addrs[$urandom_range(0, 9)];
      if (!dw) a = a | 24'($urandom_range(0, 1));
      exp = model_read(dw, a);
      mmio(rnw, dw, a, {$urandom, $urandom}, acks, rd, par, rdy);
      n_checks++;
      if (acks !== 3'b010) begin
        n_fail++; $display("FAIL rnd_ack_timing: got %03b expected 010", acks);
      end
      n_checks++;
      if (rnw) begin
        if (rd !== exp || par !== ~^exp) begin
          n_fail++; $display("FAIL rnd_read addr=%06h dw=%0d: got %h/%b expected %h/%b",
                             a, dw, rd, par, exp, ~^exp);
        end
      end else if (cu_configure !== m_cfg || cu_configure_2 !== m_cfg2 ||
                   {err_ready, done_ready, ret_ready} !== {!m_full[2], !m_full[1], !m_full[0]}) begin
        n_fail++; $display("FAIL rnd_write addr=%06h: cfg=%h cfg2=%h rdy=%03b expected %h %h %03b",
                           a, cu_configure, cu_configure_2, {err_ready, done_ready, ret_ready},
                           m_cfg, m_cfg2, {!m_full[2], !m_full[1], !m_full[0]});
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_rnw = 1'b0; req_dw = 1'b0; req_addr = '0; req_data = '0;
    ret_valid = 1'b0; done_valid = 1'b0; err_valid = 1'b0;
    ret_data = '0; done_data = '0; err_data = '0;
    cu_status_in = '0;
    model_reset();
    test_reset();
    test_config();
    test_mailbox();
    test_ack_with_push();
    test_status32();
    test_unmapped();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
